// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial-product bit per clock, unsigned or
// two's-complement signed operands, valid/ready handshakes on both sides.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic             accept_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [WIDTH:0]   sum_c;
  logic [AW-1:0]    acc_next_c;
  logic [PW-1:0]    prod_c;

  // In DONE a new operation may be accepted on the same edge the result is taken.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign accept_c  = in_valid && in_ready;

  // Magnitudes of the operands; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits.
  always_comb begin
    mag_a_c = in_a;
    mag_b_c = in_b;
    if (in_signed && in_a[WIDTH-1]) mag_a_c = WIDTH'(-in_a);
    if (in_signed && in_b[WIDTH-1]) mag_b_c = WIDTH'(-in_b);
  end

  // Low WIDTH bits of acc hold the remaining multiplier bits; upper bits collect sums.
  always_comb begin
    sum_c      = acc[AW-1:WIDTH] + (acc[0] ? {1'b0, mcand} : '0);
    acc_next_c = {1'b0, sum_c, acc[WIDTH-1:1]};
    prod_c     = neg ? PW'(-acc_next_c[PW-1:0]) : acc_next_c[PW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      out_p <= '0;
    end else if (accept_c) begin
      state <= BUSY;
      mcand <= mag_a_c;
      acc   <= AW'(mag_b_c);
      cnt   <= CW'(WIDTH);
      neg   <= in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    end else begin
      case (state)
        BUSY: begin
          acc <= acc_next_c;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            out_p <= prod_c;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=3 and WIDTH=8 against an
// integer-arithmetic reference model.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a, b;
  logic        sg;
  logic        v3, or3, ir3, ov3, bz3;
  logic [5:0]  p3;
  logic        v8, or8, ir8, ov8, bz8;
  logic [15:0] p8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(ir3),
    .in_a(a[2:0]), .in_b(b[2:0]), .in_signed(sg),
    .out_valid(ov3), .out_ready(or3), .out_p(p3), .busy(bz3)
  );

  seq_multiplier #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8),
    .in_a(a), .in_b(b), .in_signed(sg),
    .out_valid(ov8), .out_ready(or8), .out_p(p8), .busy(bz8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as integers, multiply, keep 2*w low bits.
  function automatic logic [15:0] model(input int w, input logic [7:0] ta,
                                        input logic [7:0] tb, input logic ts);
    longint x, y, m;
    m = (longint'(1) << w) - 1;
    x = longint'(ta) & m;
    y = longint'(tb) & m;
    if (ts && x[w-1]) x = x - (longint'(1) << w);
    if (ts && y[w-1]) y = y - (longint'(1) << w);
    return 16'((x * y) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // One full transaction; called and returns at a falling edge.
  task automatic run(input bit w3, input logic [7:0] ta, input logic [7:0] tb,
                     input logic ts, input string tag);
    int lat;
    int w;
    logic [15:0] exp;
    w   = w3 ? 3 : 8;
    exp = model(w, ta, tb, ts);
    a = ta; b = tb; sg = ts;
    if (w3) v3 = 1'b1; else v8 = 1'b1;
    check({tag, "_in_ready"}, 32'(w3 ? ir3 : ir8), 32'd1);
    @(posedge clk); @(negedge clk);
    v3 = 1'b0; v8 = 1'b0;
    lat = 0;
    while (!(w3 ? ov3 : ov8) && lat < 40) begin
      a = 8'($urandom); b = 8'($urandom); sg = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(w));
    check({tag, "_product"}, w3 ? 32'(p3) : 32'(p8), 32'(exp));
    check({tag, "_busy"}, 32'(w3 ? bz3 : bz8), 32'd0);
    if (w3) or3 = 1'b1; else or8 = 1'b1;
    @(posedge clk); @(negedge clk);
    or3 = 1'b0; or8 = 1'b0;
    check({tag, "_valid_drop"}, 32'(w3 ? ov3 : ov8), 32'd0);
  endtask

  initial begin
    logic [15:0] held, exp;
    logic [7:0]  oa [3];
    logic [7:0]  ob [3];
    logic        os [3];
    logic [15:0] q [$];
    int          acc_cyc [$];
    int          n_acc, n_res, lat;
    bit          acc_now, con_now, seen;

    rst_n = 1'b0; v3 = 0; v8 = 0; or3 = 0; or8 = 0; a = 0; b = 0; sg = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready8", 32'(ir8), 32'd1);
    check("rst_valid8", 32'(ov8), 32'd0);
    check("rst_busy8", 32'(bz8), 32'd0);
    check("rst_p8", 32'(p8), 32'd0);
    check("rst_ready3", 32'(ir3), 32'd1);
    check("rst_p3", 32'(p3), 32'd0);

    // WIDTH=3: corner case then exhaustive unsigned.
    run(1'b1, 8'd7, 8'd7, 1'b0, "w3_7x7");
    check("w3_7x7_const", 32'(p3), 32'd49);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        run(1'b1, 8'(i), 8'(j), 1'b0, "w3_exh");

    // WIDTH=8 directed corners and random mix.
    run(1'b0, 8'hFD, 8'd5,  1'b1, "s_m3x5");
    check("s_m3x5_const", 32'(p8), 32'h0000FFF1);
    run(1'b0, 8'h80, 8'h80, 1'b1, "s_m128sq");
    check("s_m128sq_const", 32'(p8), 32'h00004000);
    run(1'b0, 8'h80, 8'h7F, 1'b1, "s_m128x127");
    check("s_m128x127_const", 32'(p8), 32'h0000C080);
    run(1'b0, 8'hFF, 8'hFF, 1'b0, "u_255sq");
    check("u_255sq_const", 32'(p8), 32'h0000FE01);
    run(1'b0, 8'h00, 8'h00, 1'b1, "s_zero");
    for (int i = 0; i < 30; i++)
      run(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), "rand8");

    // Backpressure: hold the result in DONE for 10 cycles.
    exp = model(8, 8'd200, 8'd100, 1'b0);
    a = 8'd200; b = 8'd100; sg = 1'b0; v8 = 1'b1;
    @(posedge clk); @(negedge clk);
    v8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 40) begin @(negedge clk); lat++; end
    check("bp_reach_done", 32'(ov8), 32'd1);
    held = p8;
    check("bp_product", 32'(held), 32'(exp));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin a = 8'd9; b = 8'd9; v8 = 1'b1; end
      else v8 = 1'b0;
      check("bp_in_ready", 32'(ir8), 32'd0);
      @(posedge clk); @(negedge clk);
      check("bp_valid", 32'(ov8), 32'd1);
      check("bp_hold", 32'(p8), 32'(held));
    end
    v8 = 1'b0; or8 = 1'b1;
    @(posedge clk); @(negedge clk);
    or8 = 1'b0;
    check("bp_idle_valid", 32'(ov8), 32'd0);
    check("bp_idle_ready", 32'(ir8), 32'd1);
    check("bp_idle_busy", 32'(bz8), 32'd0);
    check("bp_p_kept", 32'(p8), 32'(held));

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) begin
      oa[i] = 8'($urandom); ob[i] = 8'($urandom); os[i] = 1'($urandom);
    end
    a = oa[0]; b = ob[0]; sg = os[0]; v8 = 1'b1; or8 = 1'b1;
    n_acc = 0; n_res = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      acc_now = v8 && ir8;
      con_now = ov8 && or8;
      if (con_now) begin
        if (q.size() == 0) check("b2b_spurious", 32'd1, 32'd0);
        else check("b2b_p", 32'(p8), 32'(q.pop_front()));
        n_res++;
      end
      if (acc_now) begin
        acc_cyc.push_back(cyc);
        q.push_back(model(8, oa[n_acc], ob[n_acc], os[n_acc]));
        n_acc++;
      end
      @(posedge clk); @(negedge clk);
      if (acc_now) begin
        if (n_acc < 3) begin a = oa[n_acc]; b = ob[n_acc]; sg = os[n_acc]; end
        else v8 = 1'b0;
      end
      if (n_acc == 3 && q.size() == 0) break;
    end
    or8 = 1'b0; v8 = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd3);
    check("b2b_results", 32'(n_res), 32'd3);
    if (acc_cyc.size() == 3) begin
      check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd9);
      check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd9);
    end else begin
      check("b2b_accept_count", 32'(acc_cyc.size()), 32'd3);
    end

    // Mid-operation reset at BUSY cycle 4 aborts the operation.
    a = 8'd200; b = 8'd100; sg = 1'b0; v8 = 1'b1;
    @(posedge clk); @(negedge clk);
    v8 = 1'b0;
    repeat (3) @(negedge clk);
    check("mr_busy_before", 32'(bz8), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("mr_valid", 32'(ov8), 32'd0);
    check("mr_p", 32'(p8), 32'd0);
    check("mr_ready", 32'(ir8), 32'd1);
    check("mr_busy", 32'(bz8), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov8) seen = 1'b1;
    end
    check("mr_no_stale_result", 32'(seen), 32'd0);
    run(1'b0, 8'd3, 8'd4, 1'b0, "mr_3x4");
    check("mr_3x4_const", 32'(p8), 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
